// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl: sequencer for the 8x8 Game of Life next-generation datapath.
// Holds the current grid, feeds it to the external combinational datapath and
// captures the datapath result on run ticks or single steps. Stops on still
// life, extinction or a generation limit.
module life_gen_ctrl #(
  parameter int CELLS = 64,
  parameter int DIV_W = 24,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CELLS-1:0] seed,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [DIV_W-1:0] period,
  input  logic [GEN_W-1:0] max_gen,
  input  logic [CELLS-1:0] next_grid,
  output logic [CELLS-1:0] grid,
  output logic             gen_pulse,
  output logic [GEN_W-1:0] gen_count,
  output logic             running,
  output logic             done,
  output logic             stable,
  output logic             extinct
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t           r_state;
  logic [CELLS-1:0] r_grid;
  logic [DIV_W-1:0] r_tick;
  logic [GEN_W-1:0] r_gen_count;
  logic             r_gen_pulse;
  logic             r_stable;
  logic             r_extinct;

  logic             w_same;
  logic             w_zero;
  logic [GEN_W:0]   w_cnt_plus;
  logic [GEN_W-1:0] w_cnt_sat;
  logic             w_hit_max;
  logic             w_tick_hit;
  logic             w_load_ok;
  logic             w_advance;

  assign w_same     = (next_grid == r_grid);
  assign w_zero     = (next_grid == '0);
  // One extra bit so the max_gen compare sees the true count, not the saturated one.
  assign w_cnt_plus = {1'b0, r_gen_count} + {{GEN_W{1'b0}}, 1'b1};
  assign w_cnt_sat  = w_cnt_plus[GEN_W] ? {GEN_W{1'b1}} : w_cnt_plus[GEN_W-1:0];
  assign w_hit_max  = (max_gen != '0) && (w_cnt_plus >= {1'b0, max_gen});
  assign w_tick_hit = (r_tick == period);
  assign w_load_ok  = load && (r_state != S_RUN);

  // Decide whether this cycle applies a generation (load > stop > start > step).
  always_comb begin
    // NOTE: default first so every path assigns w_advance and no latch is inferred.
    w_advance = 1'b0;
    unique case (r_state)
      S_IDLE, S_PAUSE: w_advance = !load && !stop && !start && step;
      S_RUN:           w_advance = !stop && w_tick_hit;
      default:         w_advance = 1'b0;
    endcase
  end

  // Single FSM: command handling, tick divider, grid capture and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_grid      <= '0;
      r_tick      <= '0;
      r_gen_count <= '0;
      r_gen_pulse <= 1'b0;
      r_stable    <= 1'b0;
      r_extinct   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; later assignments in this block deliberately
      // override earlier ones (the advance outcome overrides the command transition).
      r_gen_pulse <= 1'b0;

      if (w_load_ok) begin
        r_grid      <= seed;
        r_gen_count <= '0;
        r_stable    <= 1'b0;
        r_extinct   <= 1'b0;
        r_state     <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (stop) begin
              r_state <= S_IDLE;
            end else if (start) begin
              r_state <= S_RUN;
              r_tick  <= '0;
            end else if (step) begin
              r_state <= S_PAUSE;
            end
          end
          S_RUN: begin
            if (stop)            r_state <= S_PAUSE;
            else if (w_tick_hit) r_tick  <= '0;
            else                 r_tick  <= r_tick + 1'b1;
          end
          S_PAUSE: begin
            if (!stop && start) r_state <= S_RUN;
          end
          default: r_state <= S_DONE;
        endcase
      end

      if (w_advance) begin
        if (w_same) begin
          r_stable <= 1'b1;
          r_state  <= S_DONE;
        end else begin
          r_grid      <= next_grid;
          r_gen_pulse <= 1'b1;
          r_gen_count <= w_cnt_sat;
          if (w_zero) begin
            r_extinct <= 1'b1;
            r_state   <= S_DONE;
          end else if (w_hit_max) begin
            r_state <= S_DONE;
          end
        end
      end
    end
  end

  assign grid      = r_grid;
  assign gen_pulse = r_gen_pulse;
  assign gen_count = r_gen_count;
  assign running   = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign stable    = r_stable;
  assign extinct   = r_extinct;

endmodule
